// File: rtl/quad_sample_sched_pkg.sv
// Shared definitions for the quadrature-encoder sampling scheduler:
// FSM state encoding, channel-index and sequence widths, and the
// millisecond cycle count derived from the clock frequency.
// Optional feature macro: QUAD_SAMPLE_SCHED_SEQ_EN (round sequence counter).
package quad_sample_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Width of the channel index presented with each sample (up to 8 channels).
  localparam int CH_W  = 3;

  // Width of the round sequence number.
  localparam int SEQ_W = 8;

  localparam int MS_PER_S = 1000;

  // Clock cycles per millisecond; never below one so the tick divider stays sane.
  function automatic int ms_cycles(input int clk_frequency);
    int cyc;
    cyc = clk_frequency / MS_PER_S;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/quad_sample_sched_if.sv
// Sample handshake between the scheduler (master) and the downstream
// register bank / host logic (slave). The master presents one channel's
// delta at a time; the slave accepts it with sample_ack.
interface quad_sample_sched_if
  import quad_sample_sched_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                    sample_valid;
  logic [CH_W-1:0]         sample_ch;
  logic signed [CNT_W-1:0] sample_delta;
  logic [SEQ_W-1:0]        sample_seq;
  logic                    sample_ack;

  modport master (
    output sample_valid,
    output sample_ch,
    output sample_delta,
    output sample_seq,
    input  sample_ack
  );

  modport slave (
    input  sample_valid,
    input  sample_ch,
    input  sample_delta,
    input  sample_seq,
    output sample_ack
  );

endinterface

// File: rtl/timer_pulse.sv
// Programmable millisecond pulse generator. Emits a one-cycle tick every
// rate_ms milliseconds. The period is captured when a period starts, so a
// new rate_ms only applies once the running period has expired. rate_ms=0
// stops the timer after the current period; it restarts as soon as a
// non-zero rate is seen again.
module timer_pulse
  import quad_sample_sched_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rate_ms,
  output logic       tick
);

  localparam int MS_CYCLES = ms_cycles(CLK_FREQUENCY);
  localparam int SUB_W     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(MS_CYCLES - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic [7:0]       ms_cnt;
  logic [7:0]       period;
  logic             running;

  // Two-level divider: sub_cnt counts cycles within a millisecond, ms_cnt
  // counts milliseconds within the captured period.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt <= '0;
      ms_cnt  <= '0;
      period  <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!running) begin
        if (rate_ms != 8'd0) begin
          period  <= rate_ms;
          running <= 1'b1;
          sub_cnt <= '0;
          ms_cnt  <= '0;
        end
      end else if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (ms_cnt == period - 8'd1) begin
          tick    <= 1'b1;
          ms_cnt  <= '0;
          period  <= rate_ms;
          running <= (rate_ms != 8'd0);
        end else begin
          ms_cnt <= ms_cnt + 8'd1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_sample_sched.sv
// Periodic sampling scheduler for the quadrature-encoder peripheral.
// On each timer tick (while enabled) all encoder counters are snapshotted,
// then the signed per-channel deltas since the previous accepted sample are
// streamed out one channel at a time over a valid/ack handshake. A one-cycle
// irq marks round completion; a tick arriving mid-round sets sticky overrun.
// Optional feature macro: QUAD_SAMPLE_SCHED_SEQ_EN builds the round sequence
// counter; without it sample_seq is tied to zero.
module quad_sample_sched
  import quad_sample_sched_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rate_ms,
  input  logic                    enable,
  input  logic [NUM_CH*CNT_W-1:0] enc_count,
  input  logic                    overrun_clr,
  output logic                    irq,
  output logic                    overrun,
  quad_sample_sched_if.master     smp
);

  // Index width into the per-channel arrays (at least one bit).
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    valid_q, valid_d;
  logic signed [CNT_W-1:0] delta_q, delta_d;
  logic                    irq_q, irq_d;
  logic                    overrun_q;
  logic                    tick;
  logic                    hs;
  logic                    drop;
  logic                    latch_en;
  logic [IDX_W-1:0]        cur_idx;
  logic [IDX_W-1:0]        nxt_idx;

  logic [CNT_W-1:0] snap [NUM_CH];
  logic [CNT_W-1:0] prev [NUM_CH];

  // Counter difference taken modulo 2^CNT_W, so a counter that wrapped
  // between samples still yields the correct signed movement.
  function automatic logic signed [CNT_W-1:0] wrap_delta(
    input logic [CNT_W-1:0] now_v,
    input logic [CNT_W-1:0] old_v
  );
    logic [CNT_W-1:0] diff;
    diff = now_v - old_v;
    return $signed(diff);
  endfunction

  timer_pulse #(
    .CLK_FREQUENCY (CLK_FREQUENCY)
  ) u_timer (
    .clk     (clk),
    .rst     (~reset),
    .rate_ms (rate_ms),
    .tick    (tick)
  );

  assign hs      = valid_q & smp.sample_ack;
  assign drop    = tick & (state_q != ST_IDLE);
  assign cur_idx = ch_q[IDX_W-1:0];
  assign nxt_idx = IDX_W'(ch_q + 1'b1);

  // Next-state and next-output logic; outputs are precomputed here so the
  // registered sample moves to the next channel with no bubble after an ack.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    valid_d  = valid_q;
    delta_d  = delta_q;
    irq_d    = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && enable) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch_en = 1'b1;
        ch_d     = '0;
        valid_d  = 1'b1;
        delta_d  = wrap_delta(enc_count[CNT_W-1:0], prev[0]);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          if (ch_q == LAST_CH) begin
            valid_d = 1'b0;
            irq_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            delta_d = wrap_delta(snap[nxt_idx], prev[nxt_idx]);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      valid_q <= 1'b0;
      delta_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      delta_q <= delta_d;
      irq_q   <= irq_d;
    end
  end

  // Snapshot of all counter lanes, taken once per round in LATCH.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap[i] <= enc_count[i*CNT_W +: CNT_W];
      end
    end
  end

  // Reference values advance only when the downstream accepts a channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev[i] <= '0;
      end
    end else if (hs) begin
      prev[cur_idx] <= snap[cur_idx];
    end
  end

  // Sticky overrun: a dropped tick takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

`ifdef QUAD_SAMPLE_SCHED_SEQ_EN
  logic [SEQ_W-1:0] seq_q;

  // Round sequence number, advanced together with the completion irq.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_q <= '0;
    end else if (irq_d) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  assign smp.sample_seq = seq_q;
`else
  assign smp.sample_seq = '0;
`endif

  assign smp.sample_valid = valid_q;
  assign smp.sample_ch    = ch_q;
  assign smp.sample_delta = delta_q;
  assign irq              = irq_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_quad_sample_sched.sv
// Self-checking bench for quad_sample_sched (NUM_CH=2, CNT_W=16, a scaled
// clock of 10 kHz so one millisecond is 10 cycles). Directed rounds cover
// reset, basic deltas, wrap, back-pressure/overrun, gating, mid-round reset
// and rate_ms=0; a randomized phase compares against a scoreboard model.
// Honours QUAD_SAMPLE_SCHED_SEQ_EN for the expected sample_seq.
module tb_quad_sample_sched;

  localparam int CLK_HZ = 10_000;
  localparam int MS_CYC = CLK_HZ / 1000;

`ifdef QUAD_SAMPLE_SCHED_SEQ_EN
  localparam logic [7:0] SEQ_MASK = 8'hFF;
`else
  localparam logic [7:0] SEQ_MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rate_ms;
  logic        enable;
  logic [31:0] enc_count;
  logic        overrun_clr;
  logic        irq;
  logic        overrun;

  quad_sample_sched_if #(.CNT_W(16)) smp ();

  quad_sample_sched #(
    .CLK_FREQUENCY (CLK_HZ),
    .NUM_CH        (2),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rate_ms     (rate_ms),
    .enable      (enable),
    .enc_count   (enc_count),
    .overrun_clr (overrun_clr),
    .irq         (irq),
    .overrun     (overrun),
    .smp         (smp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] prev_m [2];
  int          rounds_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seq_of(input int n);
    return 8'(n) & SEQ_MASK;
  endfunction

  function automatic logic [15:0] lane(input int i);
    return enc_count[i*16 +: 16];
  endfunction

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (smp.sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("valid_timeout", smp.sample_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, smp.sample_valid, 0);
    check({tag, "_ch"}, smp.sample_ch, 0);
    check({tag, "_delta"}, $unsigned(smp.sample_delta), 0);
    check({tag, "_seq"}, smp.sample_seq, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  // One complete round with enable dropped as soon as it starts; ack is
  // held low for 'hold' cycles on channel 0 before being raised.
  task automatic do_round(input int hold);
    logic [15:0] exp_d [2];
    bit ok;
    bit held;
    for (int i = 0; i < 2; i++) exp_d[i] = lane(i) - prev_m[i];
    smp.sample_ack = (hold == 0);
    enable = 1'b1;
    wait_valid(400, ok);
    if (ok) begin
      enable = 1'b0;
      check("r_ch0", smp.sample_ch, 0);
      check("r_d0", $unsigned(smp.sample_delta), exp_d[0]);
      check("r_seq", smp.sample_seq, seq_of(rounds_m));
      if (hold > 0) begin
        held = 1'b1;
        repeat (hold) begin
          @(negedge clk);
          if (!(smp.sample_valid && smp.sample_ch == 3'd0 &&
                16'(smp.sample_delta) == exp_d[0])) held = 1'b0;
        end
        check("r_hold", held, 1);
        smp.sample_ack = 1'b1;
      end
      @(negedge clk);
      check("r_v1", smp.sample_valid, 1);
      check("r_ch1", smp.sample_ch, 1);
      check("r_d1", $unsigned(smp.sample_delta), exp_d[1]);
      @(negedge clk);
      check("r_end_vld", smp.sample_valid, 0);
      check("r_irq", irq, 1);
      check("r_seq_inc", smp.sample_seq, seq_of(rounds_m + 1));
      @(negedge clk);
      check("r_irq_off", irq, 0);
      prev_m[0] = lane(0);
      prev_m[1] = lane(1);
      rounds_m++;
    end
    enable = 1'b0;
    smp.sample_ack = 1'b0;
  endtask

  // Randomized run against a scoreboard: tick spacing, per-channel deltas,
  // channel order, irq timing, sequence number and absence of overrun.
  task automatic run_random(input int cycles);
    int rate;
    logic [15:0] snap_m [2];
    bit in_round, irq_due, have_start;
    int exp_ch, cyc, last_start, rounds_here;
    in_round = 0; irq_due = 0; have_start = 0;
    exp_ch = 0; cyc = 0; last_start = 0; rounds_here = 0;
    rate = $urandom_range(2, 3);
    reset = 1'b0;
    rate_ms = 8'(rate);
    enable = 1'b0;
    smp.sample_ack = 1'b0;
    enc_count = {16'($urandom), 16'($urandom)};
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_m[0] = '0; prev_m[1] = '0;
    rounds_m = 0;
    enable = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      cyc++;
      check("m_irq", irq, irq_due);
      irq_due = 1'b0;
      if (smp.sample_valid && !in_round) begin
        in_round = 1'b1;
        exp_ch = 0;
        snap_m[0] = lane(0);
        snap_m[1] = lane(1);
        if (have_start) check("m_period", cyc - last_start, rate * MS_CYC);
        have_start = 1'b1;
        last_start = cyc;
        enc_count = {16'($urandom), 16'($urandom)};
      end
      if (in_round) begin
        check("m_vld", smp.sample_valid, 1);
        check("m_ch", smp.sample_ch, exp_ch);
        check("m_delta", $unsigned(smp.sample_delta), 16'(snap_m[exp_ch] - prev_m[exp_ch]));
        check("m_seq", smp.sample_seq, seq_of(rounds_m));
      end
      check("m_ovr", overrun, 0);
      smp.sample_ack = ($urandom_range(0, 7) != 0);
      if (in_round && smp.sample_ack) begin
        prev_m[exp_ch] = snap_m[exp_ch];
        if (exp_ch == 1) begin
          in_round = 1'b0;
          irq_due = 1'b1;
          rounds_m++;
          rounds_here++;
        end else begin
          exp_ch++;
        end
      end
    end
    check("m_rounds", (rounds_here >= cycles / (rate * MS_CYC) - 2), 1);
    enable = 1'b0;
    smp.sample_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    reset = 1'b0;
    rate_ms = 8'd0;
    enable = 1'b0;
    enc_count = '0;
    overrun_clr = 1'b0;
    smp.sample_ack = 1'b0;
    prev_m[0] = '0; prev_m[1] = '0;
    rounds_m = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    rate_ms = 8'd1;

    // Basic round: 100 and -5
    enc_count = {16'hFFFB, 16'd100};
    do_round(0);
    check("basic_ovr", overrun, 0);

    // Wrap: 0xFFF0 then 0x0010 gives +0x20
    enc_count = {16'h0000, 16'hFFF0};
    do_round(0);
    enc_count = {16'h8000, 16'h0010};
    do_round(0);
    check("wrap_ovr", overrun, 0);

    // Gating: ticks with enable low are ignored
    seen = 1'b0;
    repeat (4 * MS_CYC) begin
      @(negedge clk);
      if (smp.sample_valid) seen = 1'b1;
    end
    check("gate_novalid", seen, 0);
    check("gate_ovr", overrun, 0);

    // Back-pressure across several ticks
    enc_count = {16'h1234, 16'h0007};
    do_round(35);
    check("bp_ovr_set", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("bp_ovr_clr", overrun, 0);

    // Reset in the middle of a round
    enc_count = {16'hABCD, 16'h0F00};
    smp.sample_ack = 1'b0;
    enable = 1'b1;
    wait_valid(400, ok);
    enable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    prev_m[0] = '0; prev_m[1] = '0;
    rounds_m = 0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (irq || smp.sample_valid) seen = 1'b1;
    end
    check("mid_rst_quiet", seen, 0);
    do_round(0);

    // rate_ms = 0: timer stops after the running period
    rate_ms = 8'd0;
    repeat (3 * MS_CYC) @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (smp.sample_valid) seen = 1'b1;
    end
    enable = 1'b0;
    check("rate0_novalid", seen, 0);
    check("rate0_seq", smp.sample_seq, seq_of(rounds_m));

    // Randomized rounds
    run_random(800);
    run_random(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_sample_sched.md
# quad_sample_sched

Periodic sampling scheduler for the quadrature-encoder peripheral. An internal millisecond tick sets the sample period. On each tick the block snapshots every encoder counter, computes the signed per-channel count delta since the previous round, and presents the deltas one channel at a time over a valid/ack handshake to the downstream register bank or host-interface logic. It raises an interrupt pulse when a round completes and flags overruns when a new tick arrives before the previous round has drained.

## Interface
- CLK_FREQUENCY, 50_000_000, clock frequency in Hz; passed to the tick generator.
- NUM_CH, 2, number of encoder channels (1–8).
- CNT_W, 16, encoder counter width and delta width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rate_ms  in  8  sample period in ms; 0 disables ticks.
- enable  in  1  rounds start only while high.
- enc_count  in  NUM_CH*CNT_W  free-running encoder counters; channel i is at bits [i*CNT_W +: CNT_W].
- sample_ack  in  1  downstream accepts the current sample.
- overrun_clr  in  1  clears the sticky overrun flag.
- sample_valid  out  1  sample_ch/sample_delta are valid.
- sample_ch  out  3  channel index of the current sample.
- sample_delta  out  CNT_W  signed delta, two's complement.
- sample_seq  out  8  round sequence number (see Configuration).
- irq  out  1  one-cycle pulse at round completion.
- overrun  out  1  sticky; a tick was dropped.

## Operation
- Tick source: internal timer, one-cycle `tick` every rate_ms ms (rate_ms × CLK_FREQUENCY/1000 cycles).
  - rate_ms = 0: no ticks.
  - A change of rate_ms takes effect after the current period expires.
- FSM states: IDLE → LATCH → SEND → IDLE.
  - IDLE: on tick with enable=1, go to LATCH. A tick with enable=0 is ignored and does not set overrun.
  - LATCH: copy all enc_count lanes into snap[]; set ch=0; go to SEND.
  - SEND: sample_valid=1, sample_ch=ch, sample_delta=snap[ch]−prev[ch], computed mod 2^CNT_W so counter wrap yields the correct signed delta.
    - On sample_ack & sample_valid: prev[ch]←snap[ch].
    - If ch=NUM_CH−1: irq=1 next cycle, increment sample_seq (wraps 255→0), go to IDLE.
    - Otherwise ch←ch+1 and stay in SEND.
- A tick while in LATCH or SEND is dropped and sets overrun. The active round is unaffected.
- overrun_clr clears overrun. If a drop and overrun_clr occur in the same cycle, set wins.
- enable falling mid-round does not abort the round. The round completes.
- sample_ack while sample_valid=0 is ignored.
- prev[] resets to 0, so the first round reports delta = counter value minus 0.

## Timing
- Reset (reset=0 at a clk edge): state=IDLE; sample_valid=0, sample_ch=0, sample_delta=0, sample_seq=0, irq=0, overrun=0; prev[]=0; tick counter restarts. This applies mid-round as well: the round is abandoned and no irq is issued.
- Tick in cycle T (IDLE, enable=1): LATCH in T+1; sample_valid=1 with ch 0 in T+2.
- Ack in cycle A for a non-last channel: the next channel is presented in A+1 with sample_valid held high (no bubble).
- Ack for the last channel in cycle A: sample_valid=0 and irq=1 in A+1; irq=0 in A+2.
- Minimum round length: NUM_CH+2 cycles after the tick.
- All outputs are registered.

## Configuration
- QUAD_SAMPLE_SCHED_SEQ_EN defined: sample_seq increments once per completed round.
- Undefined: the sample_seq counter is not built and sample_seq is tied to 0. All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_LATCH, ST_SEND).
  - MS_CYCLES = CLK_FREQUENCY/1000.
  - Channel-index width constant (3).
- One sub-module: timer_pulse (existing block), parameterised with CLK_FREQUENCY and driven by rate_ms. Its reset is active-high, so it is connected to ~reset.

## Test plan
- Basic round: CLK_FREQUENCY=50_000_000, rate_ms=1, NUM_CH=2, counts 100/−5, ack tied high → after 50_000 cycles, deltas 100 then 0xFFFB on ch 0/1 in consecutive cycles, then irq one cycle, sample_seq=1.
- Wrap: prev=0xFFF0, count=0x0010 → sample_delta=0x0020.
- Back-pressure: ack held low for 60_000 cycles → sample_valid stays high with ch 0; the second tick sets overrun; after ack, the round completes normally; overrun_clr pulse → overrun=0.
- Gating: enable=0 across a tick → no sample_valid, overrun stays 0. enable deasserted mid-round → round still completes with irq.
- Reset mid-round: reset=0 while in SEND → next cycle all outputs are at reset values and no irq. The next round reports the full counter values.
- rate_ms=0 for 200_000 cycles → no sample_valid; macro undefined → sample_seq=0 throughout.
